// File: rtl/detect_faces_div_27s_16ns_seq.sv
// rtl/detect_faces_div_27s_16ns_seq.sv - radix-2 restoring signed/unsigned divider, C truncation semantics
// Optional divide-by-zero flag and saturation: DIV_BY_ZERO_FLAG_EN
module detect_faces_div_27s_16ns_seq #(
    parameter int din0_WIDTH = 27,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 27
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] dout,
`ifdef DIV_BY_ZERO_FLAG_EN
    output logic                  div_by_zero,
`endif
    output logic [din1_WIDTH:0]   rem_out
);

    localparam int RW = din1_WIDTH + 1;
    localparam int CW = $clog2(din0_WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(din0_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nx;
    logic   load;
    logic   skip_calc;

    // dvd_q shifts dividend bits out of its MSB while quotient bits enter its LSB
    logic [din0_WIDTH-1:0] dvd_q;
    logic [din1_WIDTH-1:0] dsr_q;
    logic [RW-1:0]         rem_q;
    logic                  sign_q;
    logic [CW-1:0]         cnt_q;

    logic [din0_WIDTH-1:0] din0_mag;
    logic [RW-1:0]         shifted;
    logic [RW:0]           trial;
    logic                  qbit;

`ifdef DIV_BY_ZERO_FLAG_EN
    assign skip_calc = ~|din1;
`else
    assign skip_calc = 1'b0;
`endif

    assign din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;
    assign shifted  = {rem_q[RW-2:0], dvd_q[din0_WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, dsr_q};
    assign qbit     = ~trial[RW];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    load     = 1'b1;
                    state_nx = skip_calc ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                if (ap_start) begin
                    load     = 1'b1;
                    state_nx = skip_calc ? S_FIX : S_CALC;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            sign_q <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            dvd_q  <= din0_mag;
            dsr_q  <= din1;
            rem_q  <= '0;
            sign_q <= din0[din0_WIDTH-1];
            cnt_q  <= CNT_INIT;
        end else if (state == S_CALC) begin
            dvd_q <= {dvd_q[din0_WIDTH-2:0], qbit};
            rem_q <= qbit ? trial[RW-1:0] : shifted;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

`ifdef DIV_BY_ZERO_FLAG_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            div_by_zero <= 1'b0;
        end else if (load) begin
            div_by_zero <= ~|din1;
        end
    end
`endif

    // Results change only on the FIX->DONE edge so they hold across idle and the next CALC
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout    <= '0;
            rem_out <= '0;
        end else if (state == S_FIX) begin
`ifdef DIV_BY_ZERO_FLAG_EN
            if (div_by_zero) begin
                dout    <= sign_q ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                  : {1'b0, {(dout_WIDTH-1){1'b1}}};
                rem_out <= '0;
            end else begin
                dout    <= sign_q ? -dvd_q : dvd_q;
                rem_out <= sign_q ? -rem_q : rem_q;
            end
`else
            dout    <= sign_q ? -dvd_q : dvd_q;
            rem_out <= sign_q ? -rem_q : rem_q;
`endif
        end
    end

endmodule

// File: tb/tb_detect_faces_div_27s_16ns_seq.sv
// tb/tb_detect_faces_div_27s_16ns_seq.sv - directed vector bench for the sequential divider
module tb_detect_faces_div_27s_16ns_seq;

    logic               ap_clk;
    logic               ap_rst_n;
    logic               ap_start;
    logic signed [26:0] din0;
    logic        [15:0] din1;
    logic               ap_idle;
    logic               ap_ready;
    logic               ap_done;
    logic signed [26:0] dout;
    logic signed [16:0] rem_out;
`ifdef DIV_BY_ZERO_FLAG_EN
    logic               div_by_zero;
`endif

    int total = 0;
    int bad   = 0;

    detect_faces_div_27s_16ns_seq #(
        .din0_WIDTH(27),
        .din1_WIDTH(16),
        .dout_WIDTH(27)
    ) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_start(ap_start),
        .din0    (din0),
        .din1    (din1),
        .ap_idle (ap_idle),
        .ap_ready(ap_ready),
        .ap_done (ap_done),
        .dout    (dout),
`ifdef DIV_BY_ZERO_FLAG_EN
        .div_by_zero(div_by_zero),
`endif
        .rem_out (rem_out)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic signed [26:0] a;
        logic        [15:0] b;
        logic signed [26:0] q;
        logic signed [16:0] r;
        int                 lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Issue one request; cycle 1 is the first cycle after the accepting edge
    task automatic run_div(input string nm, input logic signed [26:0] a, input logic [15:0] b,
                           input logic signed [26:0] q, input logic signed [16:0] r, input int lat);
        int cyc;
        int idle_bad;
        @(negedge ap_clk);
        ap_start = 1'b1;
        din0     = a;
        din1     = b;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        din0     = 27'($urandom);
        din1     = 16'($urandom);
        cyc      = 0;
        idle_bad = 0;
        do begin
            @(negedge ap_clk);
            cyc++;
            if (ap_idle) idle_bad++;
        end while (!ap_done && cyc < 100);
        chk({nm, " latency"}, cyc, lat);
        chk({nm, " ready"}, int'(ap_ready), 1);
        chk({nm, " idle_low"}, idle_bad, 0);
        chk({nm, " quot"}, int'(dout), int'(q));
        chk({nm, " rem"}, int'(rem_out), int'(r));
    endtask

    initial begin
        int cyc;
        int idle_bad;
        int n_done;

        vecs[0]  = '{27'sd1000, 16'd7, 27'sd142, 17'sd6, 29};
        vecs[1]  = '{-27'sd1000, 16'd7, -27'sd142, -17'sd6, 29};
        vecs[2]  = '{-27'sd6, 16'd7, 27'sd0, -17'sd6, 29};
        vecs[3]  = '{-27'sd67108864, 16'd1, -27'sd67108864, 17'sd0, 29};
        vecs[4]  = '{27'sd67108863, 16'd65535, 27'sd1024, 17'sd1023, 29};
        vecs[5]  = '{-27'sd67108864, 16'd65535, -27'sd1024, -17'sd1024, 29};
        vecs[6]  = '{27'sd67108863, 16'd1, 27'sd67108863, 17'sd0, 29};
        vecs[7]  = '{27'sd0, 16'd5, 27'sd0, 17'sd0, 29};
        vecs[8]  = '{-27'sd1, 16'd1, -27'sd1, 17'sd0, 29};
        vecs[9]  = '{27'sd123456, 16'd1000, 27'sd123, 17'sd456, 29};
        vecs[10] = '{-27'sd123456, 16'd1000, -27'sd123, -17'sd456, 29};
        vecs[11] = '{27'sd65535, 16'd65535, 27'sd1, 17'sd0, 29};
        vecs[12] = '{27'sd5, 16'd9, 27'sd0, 17'sd5, 29};
        vecs[13] = '{27'sd1000, 16'd7, 27'sd142, 17'sd6, 29};

        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst idle", int'(ap_idle), 1);
        chk("rst done", int'(ap_done), 0);
        chk("rst ready", int'(ap_ready), 0);
        chk("rst dout", int'(dout), 0);
        chk("rst rem", int'(rem_out), 0);
        ap_rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat);
        end

        // Back-to-back: start held high, second operands presented during CALC of the first
        @(negedge ap_clk);
        ap_start = 1'b1;
        din0     = 27'sd100;
        din1     = 16'd3;
        @(posedge ap_clk);
        #1;
        din0     = 27'sd50;
        din1     = 16'd5;
        cyc      = 0;
        idle_bad = 0;
        n_done   = 0;
        while (n_done < 2 && cyc < 150) begin
            @(negedge ap_clk);
            cyc++;
            if (ap_idle) idle_bad++;
            if (ap_done) begin
                n_done++;
                if (n_done == 1) begin
                    chk("b2b first cycle", cyc, 29);
                    chk("b2b first quot", int'(dout), 33);
                    chk("b2b first rem", int'(rem_out), 1);
                end else begin
                    ap_start = 1'b0;
                    chk("b2b second cycle", cyc, 58);
                    chk("b2b second quot", int'(dout), 10);
                    chk("b2b second rem", int'(rem_out), 0);
                end
            end
        end
        ap_start = 1'b0;
        chk("b2b done count", n_done, 2);
        chk("b2b idle low", idle_bad, 0);
        @(negedge ap_clk);
        chk("b2b back to idle", int'(ap_idle), 1);

        // Async reset at cycle 10 of a division; previous result 10 r0 is replaced by 142 r6 first
        run_div("pre_rst", 27'sd1000, 16'd7, 27'sd142, 17'sd6, 29);
        @(negedge ap_clk);
        ap_start = 1'b1;
        din0     = 27'sd1000;
        din1     = 16'd7;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("abort dout", int'(dout), 0);
        chk("abort rem", int'(rem_out), 0);
        chk("abort idle", int'(ap_idle), 1);
        chk("abort done", int'(ap_done), 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        n_done   = 0;
        repeat (40) begin
            @(negedge ap_clk);
            if (ap_done) n_done++;
        end
        chk("abort no done", n_done, 0);
        run_div("post_rst", 27'sd9, 16'd2, 27'sd4, 17'sd1, 29);

`ifdef DIV_BY_ZERO_FLAG_EN
        run_div("dbz pos", 27'sd500, 16'd0, 27'sd67108863, 17'sd0, 2);
        chk("dbz pos flag", int'(div_by_zero), 1);
        run_div("dbz neg", -27'sd500, 16'd0, -27'sd67108864, 17'sd0, 2);
        chk("dbz neg flag", int'(div_by_zero), 1);
        run_div("dbz clear", 27'sd4, 16'd2, 27'sd2, 17'sd0, 29);
        chk("dbz cleared", int'(div_by_zero), 0);
`else
        run_div("zero pos", 27'sd500, 16'd0, -27'sd1, 17'sd500, 29);
        run_div("zero neg", -27'sd500, 16'd0, 27'sd1, -17'sd500, 29);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
